operand_entry_controller: RTL and testbench

OPERAND_ENTRY_CONTROLLER -- requirements
Module: operand_entry_controller

---
 rtl/operand_entry_controller.sv | 173 +++++++++++++++++
 tb/tb_operand_entry_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_controller.sv
// Keypad operand-entry sequencer: collects up to three digits per operand,
// launches the multiplier and supervises it with a 200-cycle timeout.
module operand_entry_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_value,
  input  logic       key_pressed,
  input  logic       mult_done,
  output logic       enable_A,
  output logic       enable_B,
  output logic       digit_load,
  output logic       clear_temp,
  output logic       clear_all,
  output logic       mult_start,
  output logic       result_valid,
  output logic       timeout_err,
  output logic [2:0] state,
  output logic [1:0] digit_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER_A = 3'd1,
    S_ENTER_B = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  localparam logic [3:0] KEY_STAR       = 4'hA;
  localparam logic [3:0] KEY_HASH       = 4'hB;
  localparam logic [3:0] KEY_CLEAR      = 4'hC;
  localparam logic [1:0] MAX_DIGITS     = 2'd3;
  localparam logic [7:0] TIMEOUT_CYCLES = 8'd200;

  state_t     state_q, state_d;
  logic [1:0] count_q, count_d;
  logic [7:0] timer_q, timer_d;
  logic       terr_q, terr_d;
  logic       key_prev_q, armed_q;
  logic       load_d, ctemp_d, call_d, mstart_d;
  logic       load_q, ctemp_q, call_q, mstart_q;
  logic       ena_q, enb_q, valid_q;

  logic key_event, is_digit, is_star, is_hash, is_clear;

  // armed_q stays low until the key is seen released, so a key held through
  // reset cannot masquerade as a fresh press.
  assign key_event = key_pressed & ~key_prev_q & armed_q;
  assign is_digit  = (key_value <= 4'd9);
  assign is_star   = (key_value == KEY_STAR);
  assign is_hash   = (key_value == KEY_HASH);
  assign is_clear  = (key_value == KEY_CLEAR);

  // Multiplier handshake: mult_start is a one-cycle request; mult_done is a
  // one-cycle completion pulse that is only honoured while waiting for it.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    terr_d   = terr_q;
    load_d   = 1'b0;
    ctemp_d  = 1'b0;
    call_d   = 1'b0;
    mstart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_event && is_digit) begin
          state_d = S_ENTER_A;
          load_d  = 1'b1;
          count_d = 2'd1;
          terr_d  = 1'b0;
        end else if (key_event && is_clear) begin
          call_d  = 1'b1;
          count_d = 2'd0;
        end
      end
      S_ENTER_A, S_ENTER_B: begin
        if (key_event && is_clear) begin
          state_d = S_IDLE;
          call_d  = 1'b1;
          count_d = 2'd0;
        end else if (key_event && is_digit) begin
          if (count_q != MAX_DIGITS) begin
            load_d  = 1'b1;
            count_d = count_q + 2'd1;
          end
        end else if (key_event && is_star && state_q == S_ENTER_A && count_q != 2'd0) begin
          state_d = S_ENTER_B;
          ctemp_d = 1'b1;
          count_d = 2'd0;
        end else if (key_event && is_hash && state_q == S_ENTER_B && count_q != 2'd0) begin
          state_d  = S_START;
          mstart_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        timer_d = 8'd0;
      end
      S_WAIT: begin
        if (mult_done) begin
          state_d = S_SHOW;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT_CYCLES) begin
            state_d = S_IDLE;
            terr_d  = 1'b1;
            call_d  = 1'b1;
            count_d = 2'd0;
          end
        end
      end
      S_SHOW: begin
        if (key_event && is_clear) begin
          state_d = S_IDLE;
          call_d  = 1'b1;
          count_d = 2'd0;
        end else if (key_event && is_digit) begin
          state_d = S_ENTER_A;
          call_d  = 1'b1;
          load_d  = 1'b1;
          count_d = 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      timer_q    <= 8'd0;
      terr_q     <= 1'b0;
      key_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      load_q     <= 1'b0;
      ctemp_q    <= 1'b0;
      call_q     <= 1'b0;
      mstart_q   <= 1'b0;
      ena_q      <= 1'b0;
      enb_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      terr_q     <= terr_d;
      key_prev_q <= key_pressed;
      armed_q    <= armed_q | ~key_pressed;
      load_q     <= load_d;
      ctemp_q    <= ctemp_d;
      call_q     <= call_d;
      mstart_q   <= mstart_d;
      ena_q      <= (state_d == S_ENTER_A);
      enb_q      <= (state_d == S_ENTER_B);
      valid_q    <= (state_d == S_SHOW);
    end
  end

  assign state        = state_q;
  assign digit_count  = count_q;
  assign enable_A     = ena_q;
  assign enable_B     = enb_q;
  assign digit_load   = load_q;
  assign clear_temp   = ctemp_q;
  assign clear_all    = call_q;
  assign mult_start   = mstart_q;
  assign result_valid = valid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_operand_entry_controller.sv
// Bench for operand_entry_controller: directed scenarios plus random key
// traffic, every cycle compared against a behavioural model of the keypad flow.
module tb_operand_entry_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_value;
  logic       key_pressed;
  logic       mult_done;
  logic       enable_A, enable_B, digit_load, clear_temp, clear_all;
  logic       mult_start, result_valid, timeout_err;
  logic [2:0] state;
  logic [1:0] digit_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_load, n_ctemp, n_call, n_mstart, n_wait;
  bit rand_done_en = 1'b0;

  operand_entry_controller dut (
    .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
    .mult_done(mult_done), .enable_A(enable_A), .enable_B(enable_B),
    .digit_load(digit_load), .clear_temp(clear_temp), .clear_all(clear_all),
    .mult_start(mult_start), .result_valid(result_valid),
    .timeout_err(timeout_err), .state(state), .digit_count(digit_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // phase follows the visible mode numbering: 0 idle, 1 first operand,
  // 2 second operand, 3 launch, 4 multiplying, 5 showing product.
  typedef struct packed {
    int phase;
    int digits;
    int timer;
    bit prev;
    bit armed;
    bit terr;
    bit load;
    bit ctemp;
    bit call;
    bit mstart;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic kp, logic [3:0] kv, logic md);
    model_t nx;
    bit press;
    nx = cur;
    press = kp && !cur.prev && cur.armed;
    nx.prev   = kp;
    nx.armed  = cur.armed || !kp;
    nx.load   = 1'b0;
    nx.ctemp  = 1'b0;
    nx.call   = 1'b0;
    nx.mstart = 1'b0;
    if (press && kv == 4'hC && cur.phase inside {0, 1, 2, 5}) begin
      nx.phase  = 0;
      nx.digits = 0;
      nx.call   = 1'b1;
    end else if (cur.phase == 3) begin
      nx.phase = 4;
      nx.timer = 0;
    end else if (cur.phase == 4) begin
      if (md) nx.phase = 5;
      else begin
        nx.timer = cur.timer + 1;
        if (nx.timer == 200) begin
          nx.phase  = 0;
          nx.terr   = 1'b1;
          nx.call   = 1'b1;
          nx.digits = 0;
        end
      end
    end else if (press && kv <= 4'd9) begin
      if (cur.phase == 0 || cur.phase == 5) begin
        nx.phase  = 1;
        nx.digits = 1;
        nx.load   = 1'b1;
        if (cur.phase == 0) nx.terr = 1'b0;
        else nx.call = 1'b1;
      end else if (cur.digits < 3) begin
        nx.digits = cur.digits + 1;
        nx.load   = 1'b1;
      end
    end else if (press && kv == 4'hA && cur.phase == 1 && cur.digits > 0) begin
      nx.phase  = 2;
      nx.digits = 0;
      nx.ctemp  = 1'b1;
    end else if (press && kv == 4'hB && cur.phase == 2 && cur.digits > 0) begin
      nx.phase  = 3;
      nx.mstart = 1'b1;
    end
    return nx;
  endfunction

  function automatic logic [12:0] exp_vec(model_t x);
    return {3'(x.phase), 2'(x.digits), x.phase == 1, x.phase == 2, x.load,
            x.ctemp, x.call, x.mstart, x.phase == 5, x.terr};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else m <= model_next(m, key_pressed, key_value, mult_done);
  end

  // ---------------- scoreboard ----------------
  logic [12:0] dut_vec;
  assign dut_vec = {state, digit_count, enable_A, enable_B, digit_load, clear_temp,
                    clear_all, mult_start, result_valid, timeout_err};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cycle_outputs", 32'(dut_vec), 32'(exp_vec(m)));
    if (digit_load) n_load++;
    if (clear_temp) n_ctemp++;
    if (clear_all) n_call++;
    if (mult_start) n_mstart++;
    if (state == 3'd4) n_wait++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_done_en) mult_done = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    key_value   = k;
    key_pressed = 1'b1;
    tick(hold);
    key_pressed = 1'b0;
    tick(gap);
  endtask

  task automatic key(input logic [3:0] k);
    press(k, $urandom_range(1, 3), $urandom_range(1, 2));
  endtask

  task automatic clear_counts();
    n_load = 0; n_ctemp = 0; n_call = 0; n_mstart = 0; n_wait = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int i;
    i = 0;
    while (state !== s && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; key_value = 4'h0; key_pressed = 1'b0; mult_done = 1'b0;
    clear_counts();
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_outputs", 32'(dut_vec), 32'd0);

    // Two-operand multiply: 12 * 3 with done after five waiting cycles
    clear_counts();
    key(4'd1); key(4'd2); key(4'hA); key(4'd3);
    press(4'hB, 1, 0);
    wait_state(3'd4, 10, "reach_wait");
    tick(4);
    mult_done = 1'b1;
    tick(1);
    mult_done = 1'b0;
    tick(1);
    check("mul_loads", 32'(n_load), 32'd3);
    check("mul_clear_temp", 32'(n_ctemp), 32'd1);
    check("mul_start_pulses", 32'(n_mstart), 32'd1);
    check("mul_wait_cycles", 32'(n_wait), 32'd5);
    check("mul_show_state", 32'(state), 32'd5);
    check("mul_result_valid", 32'(result_valid), 32'd1);

    // Fourth digit of an operand is dropped
    key(4'hC);
    clear_counts();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check("four_digit_loads", 32'(n_load), 32'd3);
    check("four_digit_count", 32'(digit_count), 32'd3);
    check("four_digit_enable_a", 32'({enable_A, enable_B}), 32'b10);

    // Ignored operator keys
    key(4'hC);
    clear_counts();
    key(4'hA);
    check("star_idle_state", 32'(state), 32'd0);
    check("star_idle_pulses", 32'(n_load + n_ctemp + n_call + n_mstart), 32'd0);
    key(4'd5); key(4'hA);
    clear_counts();
    key(4'hB);
    check("hash_empty_state", 32'(state), 32'd2);
    check("hash_empty_pulses", 32'(n_load + n_ctemp + n_call + n_mstart), 32'd0);
    check("hash_empty_enable_b", 32'({enable_A, enable_B}), 32'b01);

    // Multiplier never answers: timeout after 200 waiting cycles
    key(4'd7);
    clear_counts();
    press(4'hB, 1, 0);
    wait_state(3'd4, 10, "reach_wait_to");
    wait_state(3'd0, 260, "timeout_return");
    tick(1);
    check("timeout_wait_cycles", 32'(n_wait), 32'd200);
    check("timeout_clear_all", 32'(n_call), 32'd1);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    key(4'hC);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);
    key(4'd8);
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);
    check("timeout_digit_state", 32'(state), 32'd1);

    // mult_done and clear key in the same cycle: done wins
    key(4'hA); key(4'd2);
    press(4'hB, 1, 0);
    wait_state(3'd4, 10, "reach_wait_race");
    tick(2);
    clear_counts();
    mult_done = 1'b1; key_value = 4'hC; key_pressed = 1'b1;
    tick(1);
    mult_done = 1'b0; key_pressed = 1'b0;
    tick(2);
    check("race_show_state", 32'(state), 32'd5);
    check("race_no_clear_all", 32'(n_call), 32'd0);

    // Reset mid-wait with a key held down
    key(4'd1); key(4'hA); key(4'd4);
    press(4'hB, 1, 0);
    wait_state(3'd4, 10, "reach_wait_rst");
    tick(3);
    key_value = 4'd9; key_pressed = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    check("reset_immediate", 32'(dut_vec), 32'd0);
    tick(2);
    rst = 1'b0;
    clear_counts();
    tick(5);
    check("held_key_no_load", 32'(n_load), 32'd0);
    check("held_key_idle", 32'(state), 32'd0);
    key_pressed = 1'b0;
    tick(2);
    key(4'd9);
    check("repress_load", 32'(n_load), 32'd1);
    check("repress_state", 32'(state), 32'd1);

    // Random key traffic with random completion pulses
    rand_done_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      key_value = 4'($urandom_range(0, 15));
      press(key_value, $urandom_range(1, 4), $urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    rand_done_en = 1'b0;
    mult_done = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
